mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DWIDTH, default 32: data width of all read and write data buses.
REQ-002 SHALL have parameter AWIDTH_MEM, default 32: width of all address buses.
REQ-003 SHALL have parameter MEM_LAT, default 2: memory read latency in cycles from mem_ce to mem_rdata valid. Legal range is 1..15.
REQ-004 SHALL have the following ports, one per line as name, direction, width, meaning:
- ma_clk  in  1  single clock; all state updates on its rising edge.
- ma_rst  in  1  reset; asynchronous and active-low.
- if_req  in  1  instruction-fetch request, level-sensitive.
- if_addr  in  AWIDTH_MEM  fetch address.
- if_gnt  out  1  one-cycle pulse when the fetch request is accepted.
- if_valid  out  1  one-cycle pulse when if_rdata is valid.
- if_rdata  out  DWIDTH  fetched instruction.
- dm_req  in  1  data-memory request, level-sensitive.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  AWIDTH_MEM  data address.
- dm_wdata  in  DWIDTH  store data.
- dm_gnt  out  1  one-cycle pulse when the data request is accepted.
- dm_valid  out  1  one-cycle pulse at completion of a load or a store.
- dm_rdata  out  DWIDTH  load data.
- mem_ce  out  1  one-cycle access strobe to the single-port memory.
- mem_we  out  1  write enable, qualified by mem_ce.
- mem_addr  out  AWIDTH_MEM  memory address.
- mem_wdata  out  DWIDTH  memory write data.
- mem_rdata  in  DWIDTH  memory read data, valid MEM_LAT cycles after mem_ce.

Function
REQ-005 SHALL implement a three-state FSM with states IDLE, BUSY_IF and BUSY_DM.
REQ-006 SHALL, in IDLE with at least one request pending, grant exactly one requester that cycle.
- Registered outputs on the next edge: gnt pulse, mem_ce=1, mem_addr, mem_we, mem_wdata.
- The FSM enters BUSY_IF or BUSY_DM.
REQ-007 SHALL drive mem_we=dm_we only for DM grants, and mem_we=0 for IF grants.
REQ-008 SHALL drive mem_ce and mem_we high for exactly one cycle per access.
REQ-009 SHALL hold a 4-bit latency counter while in a BUSY state.
- The counter loads MEM_LAT-1 in the mem_ce cycle and decrements each cycle.
- When the counter reaches 0, the owner's valid is pulsed on the next edge.
- For loads and fetches, the owner's rdata register captures mem_rdata on that same edge.
- The FSM returns to IDLE on that same edge.
REQ-010 SHALL use the same latency for stores as for loads; dm_valid marks store completion.
REQ-011 SHALL retain if_rdata and dm_rdata between accesses; a store SHALL NOT modify dm_rdata.
REQ-012 SHALL ignore both requests while BUSY. Requesters hold req, addr, we and wdata stable until gnt, and drop req in the cycle after gnt unless issuing a new request.
REQ-013 SHALL insert exactly one IDLE cycle between the completion of one access and the next grant. Minimum access period is MEM_LAT+2 cycles.
REQ-014 SHALL keep a last_grant register (0 = IF, 1 = DM), updated on every grant.
REQ-015 SHALL, on a single pending request, grant that request regardless of last_grant.
REQ-016 SHALL never assert if_gnt and dm_gnt in the same cycle, and never assert if_valid and dm_valid in the same cycle.

Reset
REQ-017 SHALL, with ma_rst=0, immediately and asynchronously reset all state:
- FSM to IDLE, counter to 0, last_grant to 0 (IF).
- All outputs to 0, including if_rdata and dm_rdata.
REQ-018 SHALL, on reset asserted mid-access, abandon that access with no valid pulse. The first grant after reset release occurs no earlier than the first rising edge with ma_rst=1.

Configuration
REQ-019 SHALL, with macro MEM_ARBITER_RR_EN defined, resolve simultaneous requests round-robin: grant DM if last_grant=0, else grant IF.
REQ-020 SHALL, without MEM_ARBITER_RR_EN, resolve simultaneous requests with fixed DM priority: DM is always granted. last_grant is still maintained but does not affect arbitration.

Verification
REQ-021 Single fetch: MEM_LAT=2, if_req=1 with if_addr=0x10, mem_rdata=0x2002000A at the sampling edge -> if_gnt and mem_ce=1 with mem_addr=0x10 at cycle 1, if_valid=1 with if_rdata=0x2002000A at cycle 3.
REQ-022 Store: dm_req=1, dm_we=1, dm_addr=0x40, dm_wdata=0xDEADBEEF -> mem_ce=1, mem_we=1, mem_addr=0x40, mem_wdata=0xDEADBEEF for one cycle; dm_valid after MEM_LAT further cycles; dm_rdata unchanged.
REQ-023 Contention, MEM_ARBITER_RR_EN defined: both requests held continuously after reset -> grant order DM, IF, DM, IF, with grants spaced MEM_LAT+2 cycles apart.
REQ-024 Contention, macro undefined: both requests held continuously -> every grant is dm_gnt and if_gnt stays 0.
REQ-025 Reset mid-access: assert ma_rst=0 one cycle after dm_gnt -> all outputs 0 immediately and no dm_valid. After release with only if_req=1 -> if_gnt on the first active edge.
REQ-026 Request while busy: dm_req rises during BUSY_IF -> no dm_gnt until the IDLE cycle after if_valid; never two gnt pulses in one cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester (instruction fetch / data) arbiter in front of a single-port memory with fixed read latency.
// Define MEM_ARBITER_RR_EN for round-robin on contention; otherwise data requests always win.
module mem_arbiter #(
    parameter int DWIDTH     = 32,
    parameter int AWIDTH_MEM = 32,
    parameter int MEM_LAT    = 2
) (
    input  logic                  ma_clk,
    input  logic                  ma_rst,
    input  logic                  if_req,
    input  logic [AWIDTH_MEM-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_valid,
    output logic [DWIDTH-1:0]     if_rdata,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [AWIDTH_MEM-1:0] dm_addr,
    input  logic [DWIDTH-1:0]     dm_wdata,
    output logic                  dm_gnt,
    output logic                  dm_valid,
    output logic [DWIDTH-1:0]     dm_rdata,
    output logic                  mem_ce,
    output logic                  mem_we,
    output logic [AWIDTH_MEM-1:0] mem_addr,
    output logic [DWIDTH-1:0]     mem_wdata,
    input  logic [DWIDTH-1:0]     mem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    last_grant_q, last_grant_d;
    logic                    store_q, store_d;
    logic                    if_gnt_q, if_gnt_d;
    logic                    dm_gnt_q, dm_gnt_d;
    logic                    if_valid_q, if_valid_d;
    logic                    dm_valid_q, dm_valid_d;
    logic [DWIDTH-1:0]       if_rdata_q, if_rdata_d;
    logic [DWIDTH-1:0]       dm_rdata_q, dm_rdata_d;
    logic                    mem_ce_q, mem_ce_d;
    logic                    mem_we_q, mem_we_d;
    logic [AWIDTH_MEM-1:0]   mem_addr_q, mem_addr_d;
    logic [DWIDTH-1:0]       mem_wdata_q, mem_wdata_d;

    logic                    dm_wins;
    logic                    pick_dm;
    logic                    can_grant;

`ifdef MEM_ARBITER_RR_EN
    assign dm_wins = ~last_grant_q;
`else
    assign dm_wins = 1'b1;
`endif

    // A single pending request is granted regardless of arbitration history.
    assign pick_dm   = dm_req & (~if_req | dm_wins);
    // The cycle carrying a valid pulse is the mandatory idle gap before the next grant.
    assign can_grant = (if_req | dm_req) & ~if_valid_q & ~dm_valid_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        store_d      = store_q;
        if_gnt_d     = 1'b0;
        dm_gnt_d     = 1'b0;
        if_valid_d   = 1'b0;
        dm_valid_d   = 1'b0;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        mem_ce_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        unique case (state_q)
            IDLE: begin
                if (can_grant) begin
                    mem_ce_d     = 1'b1;
                    cnt_d        = LAT_M1;
                    last_grant_d = pick_dm;
                    if (pick_dm) begin
                        dm_gnt_d    = 1'b1;
                        mem_we_d    = dm_we;
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                        store_d     = dm_we;
                        state_d     = BUSY_DM;
                    end else begin
                        if_gnt_d   = 1'b1;
                        mem_addr_d = if_addr;
                        store_d    = 1'b0;
                        state_d    = BUSY_IF;
                    end
                end
            end
            BUSY_IF: begin
                if (cnt_q == 4'd0) begin
                    if_valid_d = 1'b1;
                    if_rdata_d = mem_rdata;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            BUSY_DM: begin
                if (cnt_q == 4'd0) begin
                    dm_valid_d = 1'b1;
                    if (!store_q) begin
                        dm_rdata_d = mem_rdata;
                    end
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ma_clk or negedge ma_rst) begin
        if (!ma_rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            last_grant_q <= 1'b0;
            store_q      <= 1'b0;
            if_gnt_q     <= 1'b0;
            dm_gnt_q     <= 1'b0;
            if_valid_q   <= 1'b0;
            dm_valid_q   <= 1'b0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
            mem_ce_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            store_q      <= store_d;
            if_gnt_q     <= if_gnt_d;
            dm_gnt_q     <= dm_gnt_d;
            if_valid_q   <= if_valid_d;
            dm_valid_q   <= dm_valid_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
            mem_ce_q     <= mem_ce_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign if_gnt    = if_gnt_q;
    assign dm_gnt    = dm_gnt_q;
    assign if_valid  = if_valid_q;
    assign dm_valid  = dm_valid_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign mem_ce    = mem_ce_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
